mor1kx_store_buffer_wb: RTL and testbench



---
 rtl/mor1kx_store_buffer_wb.sv | 179 +++++++++++++++++
 tb/tb_mor1kx_store_buffer_wb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_store_buffer_wb.sv
// mor1kx_store_buffer_wb: posted-write store buffer in front of the Wishbone bridge cpu_* port.
// Stores are acked once queued and drained in order; loads wait for an empty queue.
`default_nettype none

module mor1kx_store_buffer_wb #(
  parameter int DEPTH_WIDTH = 3,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_adr_i,
  input  logic [31:0]           lsu_dat_i,
  input  logic [3:0]            lsu_bsel_i,
  output logic                  lsu_ack_o,
  output logic                  lsu_err_o,
  output logic [31:0]           lsu_dat_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_adr_o,
  output logic [31:0]           bus_dat_o,
  output logic [3:0]            bus_bsel_o,
  output logic                  bus_burst_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [31:0]           bus_dat_i,
  output logic                  sb_empty_o,
  output logic                  sb_full_o,
  output logic                  store_err_o,
  output logic [ADDR_WIDTH-1:0] store_err_adr_o,
  input  logic                  err_clear_i
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_READ  = 2'd2,
    S_RDONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_q_adr  [DEPTH];
  logic [31:0]             r_q_dat  [DEPTH];
  logic [3:0]              r_q_bsel [DEPTH];
  logic [DEPTH_WIDTH-1:0]  r_wptr;
  logic [DEPTH_WIDTH-1:0]  r_rptr;
  logic [DEPTH_WIDTH:0]    r_count;

  logic                    r_bus_req;
  logic                    r_bus_we;
  logic [ADDR_WIDTH-1:0]   r_bus_adr;
  logic [31:0]             r_bus_dat;
  logic [3:0]              r_bus_bsel;
  logic                    r_lsu_ack;
  logic                    r_lsu_err;
  logic [31:0]             r_lsu_dat;
  logic                    r_store_err;
  logic [ADDR_WIDTH-1:0]   r_store_err_adr;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_store_err;

  assign w_full      = (r_count == (DEPTH_WIDTH+1)'(DEPTH));
  // The ack cycle masks the still-held request so one store is never pushed twice.
  assign w_push      = lsu_req_i & lsu_we_i & ~w_full & ~r_lsu_ack;
  assign w_pop       = (r_state == S_DRAIN) & (bus_ack_i | bus_err_i);
  assign w_store_err = (r_state == S_DRAIN) & bus_err_i;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_adr[r_wptr]  <= lsu_adr_i;
      r_q_dat[r_wptr]  <= lsu_dat_i;
      r_q_bsel[r_wptr] <= lsu_bsel_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bus_req  <= 1'b0;
      r_bus_we   <= 1'b0;
      r_bus_adr  <= '0;
      r_bus_dat  <= '0;
      r_bus_bsel <= '0;
      r_lsu_ack  <= 1'b0;
      r_lsu_err  <= 1'b0;
      r_lsu_dat  <= '0;
    end else begin
      r_lsu_ack <= w_push;
      r_lsu_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state    <= S_DRAIN;
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b1;
            r_bus_adr  <= r_q_adr[r_rptr];
            r_bus_dat  <= r_q_dat[r_rptr];
            r_bus_bsel <= r_q_bsel[r_rptr];
          end else if (lsu_req_i & ~lsu_we_i & ~r_lsu_ack) begin
            r_state    <= S_READ;
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_adr  <= lsu_adr_i;
            r_bus_bsel <= lsu_bsel_i;
          end
        end
        S_DRAIN: begin
          // Returning through IDLE leaves bus_req_o low for a cycle between accesses.
          if (bus_ack_i | bus_err_i) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
          end
        end
        S_READ: begin
          if (bus_ack_i) begin
            r_state   <= S_RDONE;
            r_bus_req <= 1'b0;
            r_lsu_dat <= bus_dat_i;
            r_lsu_ack <= 1'b1;
          end else if (bus_err_i) begin
            r_state   <= S_RDONE;
            r_bus_req <= 1'b0;
            r_lsu_dat <= '0;
            r_lsu_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store_err     <= 1'b0;
      r_store_err_adr <= '0;
    end else if (w_store_err) begin
      r_store_err <= 1'b1;
      if (~r_store_err | err_clear_i) r_store_err_adr <= r_bus_adr;
    end else if (err_clear_i) begin
      r_store_err <= 1'b0;
    end
  end

  assign lsu_ack_o       = r_lsu_ack;
  assign lsu_err_o       = r_lsu_err;
  assign lsu_dat_o       = r_lsu_dat;
  assign bus_req_o       = r_bus_req;
  assign bus_we_o        = r_bus_we;
  assign bus_adr_o       = r_bus_adr;
  assign bus_dat_o       = r_bus_dat;
  assign bus_bsel_o      = r_bus_bsel;
  assign bus_burst_o     = 1'b0;
  assign sb_empty_o      = (r_count == '0) & (r_state != S_DRAIN);
  assign sb_full_o       = w_full;
  assign store_err_o     = r_store_err;
  assign store_err_adr_o = r_store_err_adr;

endmodule

`default_nettype wire

// File: tb/tb_mor1kx_store_buffer_wb.sv
// tb_mor1kx_store_buffer_wb: vector table, hand sequences and a transaction-level
// memory/ordering model for the store buffer, with a Wishbone-like responder.
`default_nettype none

module tb_mor1kx_store_buffer_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] lsu_adr_i = '0, lsu_dat_i = '0;
  logic [3:0]  lsu_bsel_i = '0;
  logic        lsu_ack_o, lsu_err_o;
  logic [31:0] lsu_dat_o;
  logic        bus_req_o, bus_we_o, bus_burst_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_bsel_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_dat_i;
  logic        sb_empty_o, sb_full_o, store_err_o;
  logic [31:0] store_err_adr_o;
  logic        err_clear_i;

  always #5 clk = ~clk;

  mor1kx_store_buffer_wb #(.DEPTH_WIDTH(3), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_adr_i(lsu_adr_i),
    .lsu_dat_i(lsu_dat_i), .lsu_bsel_i(lsu_bsel_i),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_dat_o(lsu_dat_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_dat_o(bus_dat_o), .bus_bsel_o(bus_bsel_o), .bus_burst_o(bus_burst_o),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_dat_i(bus_dat_i),
    .sb_empty_o(sb_empty_o), .sb_full_o(sb_full_o), .store_err_o(store_err_o),
    .store_err_adr_o(store_err_adr_o), .err_clear_i(err_clear_i)
  );

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
  } tr_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    int          lat;
    bit          exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0;

  // Responder controls and observations
  int          bus_lat = 1;
  bit          hold = 0;
  int          release_cnt = 0;
  logic [31:0] err_addr = '1;
  bit          clear_now = 0, clear_with_err = 0;
  bit          acked = 0;
  int          rcnt = 0;
  int          req_cycles = 0;
  int          rsp_ack_cyc = 0;
  logic [31:0] snap_adr, snap_dat;
  logic [31:0] resp_mem  [256];
  logic [31:0] model_mem [256];
  tr_t         log_q[$];
  tr_t         exp_q[$];
  int          op_cyc = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus responder: acks (or errors) bus_lat cycles after the request is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_dat_i = '0;
      err_clear_i = 1'b0; acked = 0; rcnt = 0;
    end else begin
      err_clear_i = clear_now;
      if (bus_req_o) req_cycles++;
      if (acked) begin
        bus_ack_i = 1'b0; bus_err_i = 1'b0; acked = 0;
        chk("req_gap", {31'b0, bus_req_o}, 32'd0);
      end else if (bus_req_o) begin
        if (rcnt == 0) begin
          snap_adr = bus_adr_o; snap_dat = bus_dat_o;
        end else begin
          chk("adr_stable", bus_adr_o, snap_adr);
          if (bus_we_o) chk("dat_stable", bus_dat_o, snap_dat);
        end
        rcnt++;
        if (rcnt > bus_lat && (!hold || release_cnt > 0)) begin
          if (hold) release_cnt--;
          log_q.push_back('{bus_we_o, bus_adr_o, bus_dat_o, bus_bsel_o});
          if (bus_adr_o == err_addr) begin
            bus_err_i = 1'b1;
            if (clear_with_err) err_clear_i = 1'b1;
          end else begin
            bus_ack_i = 1'b1;
            if (bus_we_o)
              resp_mem[bus_adr_o[9:2]] = merge(resp_mem[bus_adr_o[9:2]], bus_dat_o, bus_bsel_o);
            else
              bus_dat_i = resp_mem[bus_adr_o[9:2]];
          end
          rsp_ack_cyc = cyc;
          acked = 1; rcnt = 0;
        end
      end
    end
  end

  task automatic do_op(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] bsel, output bit got_ack, output bit got_err,
                       output logic [31:0] got_dat);
    int n;
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_adr_i = adr; lsu_dat_i = dat; lsu_bsel_i = bsel;
    got_ack = 0; got_err = 0; got_dat = '0; n = 0;
    while (!got_ack && !got_err && n < 300) begin
      @(posedge clk); #1; n++;
      if (lsu_ack_o) got_ack = 1;
      if (lsu_err_o) got_err = 1;
      if (got_ack || got_err) begin got_dat = lsu_dat_o; op_cyc = cyc; end
    end
    lsu_req_i = 1'b0;
    if (!got_ack && !got_err) begin
      checks++; errors++;
      $display("FAIL op_timeout: adr %h got no completion required ack", adr);
    end
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] bsel);
    bit a, e;
    logic [31:0] d;
    do_op(1'b1, adr, dat, bsel, a, e, d);
    chk("store_ack", {31'b0, a}, 32'd1);
    exp_q.push_back('{1'b1, adr, dat, bsel});
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!(sb_empty_o && !bus_req_o) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: sb_empty_o %b required 1", sb_empty_o);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_log();
    chk("log_len", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk("log_we",   {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
      chk("log_adr",  log_q[i].adr, exp_q[i].adr);
      chk("log_bsel", {28'b0, log_q[i].bsel}, {28'b0, exp_q[i].bsel});
      if (exp_q[i].we) chk("log_dat", log_q[i].dat, exp_q[i].dat);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  vec_t vt[9];

  initial begin
    bit a, e;
    logic [31:0] d;
    bit saw;

    for (int i = 0; i < 256; i++) begin resp_mem[i] = '0; model_mem[i] = '0; end

    // Reset state
    #2;
    chk("rst_lsu_ack",   {31'b0, lsu_ack_o}, 32'd0);
    chk("rst_lsu_err",   {31'b0, lsu_err_o}, 32'd0);
    chk("rst_bus_req",   {31'b0, bus_req_o}, 32'd0);
    chk("rst_empty",     {31'b0, sb_empty_o}, 32'd1);
    chk("rst_full",      {31'b0, sb_full_o}, 32'd0);
    chk("rst_store_err", {31'b0, store_err_o}, 32'd0);
    chk("rst_err_adr",   store_err_adr_o, 32'd0);
    chk("rst_lsu_dat",   lsu_dat_o, 32'd0);
    chk("rst_burst",     {31'b0, bus_burst_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single store: ack the cycle after the push, drain with we=1 adr=0x100
    bus_lat = 2;
    @(negedge clk);
    lsu_req_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h100; lsu_dat_i = 32'hDEADBEEF; lsu_bsel_i = 4'hF;
    @(posedge clk); #1;
    chk("single_ack", {31'b0, lsu_ack_o}, 32'd1);
    lsu_req_i = 0;
    @(posedge clk); #1;
    chk("single_ack_1cyc", {31'b0, lsu_ack_o}, 32'd0);
    chk("single_req", {31'b0, bus_req_o}, 32'd1);
    chk("single_we", {31'b0, bus_we_o}, 32'd1);
    chk("single_adr", bus_adr_o, 32'h100);
    chk("single_dat", bus_dat_o, 32'hDEADBEEF);
    exp_q.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    wait_empty();
    chk("single_empty", {31'b0, sb_empty_o}, 32'd1);
    check_log();

    // Table of vectors: expected load data derived by hand from earlier stores
    err_addr = 32'h3F0;
    vt[0] = '{1'b1, 32'h40,  32'h11223344, 4'hF, 0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 32'h40,  32'hAABBCCDD, 4'h3, 3, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h40,  32'h0,        4'hF, 1, 1'b0, 32'h1122CCDD};
    vt[3] = '{1'b1, 32'h44,  32'h55667788, 4'hC, 2, 1'b0, 32'h0};
    vt[4] = '{1'b0, 32'h44,  32'h0,        4'hF, 0, 1'b0, 32'h55660000};
    vt[5] = '{1'b0, 32'h3F0, 32'h0,        4'hF, 1, 1'b1, 32'h0};
    vt[6] = '{1'b1, 32'h48,  32'hCAFEF00D, 4'hF, 5, 1'b0, 32'h0};
    vt[7] = '{1'b0, 32'h48,  32'h0,        4'hF, 0, 1'b0, 32'hCAFEF00D};
    vt[8] = '{1'b0, 32'h40,  32'h0,        4'h1, 2, 1'b0, 32'h1122CCDD};
    for (int i = 0; i < 9; i++) begin
      bus_lat = vt[i].lat;
      do_op(vt[i].we, vt[i].adr, vt[i].dat, vt[i].bsel, a, e, d);
      chk("vec_ack", {31'b0, a}, {31'b0, ~vt[i].exp_err});
      chk("vec_err", {31'b0, e}, {31'b0, vt[i].exp_err});
      if (!vt[i].we) chk("vec_rdat", d, vt[i].exp_dat);
    end
    wait_empty();
    err_addr = '1;
    log_q.delete();

    // Ordering: W10, W14, W18 then R14, read ack -> LSU ack one cycle later
    bus_lat = 1;
    store(32'h10, 32'h1, 4'hF);
    store(32'h14, 32'h2, 4'hF);
    store(32'h18, 32'h3, 4'hF);
    do_op(1'b0, 32'h14, 32'h0, 4'hF, a, e, d);
    exp_q.push_back('{1'b0, 32'h14, 32'h0, 4'hF});
    chk("order_rdat", d, 32'h2);
    chk("order_rd_latency", 32'(op_cyc), 32'(rsp_ack_cyc + 1));
    wait_empty();
    check_log();

    // Full queue: 8 acked, 9th stalls until one pop frees an entry
    hold = 1; bus_lat = 0; release_cnt = 0;
    for (int i = 0; i < 8; i++) store(32'h500 + 32'(i*4), 32'hF000 + 32'(i), 4'hF);
    @(posedge clk); #1;
    chk("full_set", {31'b0, sb_full_o}, 32'd1);
    @(negedge clk);
    lsu_req_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h520; lsu_dat_i = 32'hF008; lsu_bsel_i = 4'hF;
    saw = 0;
    repeat (6) begin @(posedge clk); #1; if (lsu_ack_o) saw = 1; end
    chk("full_stall_noack", {31'b0, saw}, 32'd0);
    release_cnt = 1;
    saw = 0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(posedge clk); #1;
      if (bus_ack_i) saw = 1;
    end
    chk("full_pop_seen", {31'b0, saw}, 32'd1);
    chk("full_drop", {31'b0, sb_full_o}, 32'd0);
    chk("full_noack_yet", {31'b0, lsu_ack_o}, 32'd0);
    @(posedge clk); #1;
    chk("full_9th_ack", {31'b0, lsu_ack_o}, 32'd1);
    chk("full_reassert", {31'b0, sb_full_o}, 32'd1);
    lsu_req_i = 0;
    exp_q.push_back('{1'b1, 32'h520, 32'hF008, 4'hF});
    hold = 0;
    wait_empty();
    check_log();

    // Back-to-back stores with fast acks: push/pop overlap and pointer wrap
    bus_lat = 0;
    for (int i = 0; i < 12; i++) store(32'h80 + 32'(i*4), 32'hA000 + 32'(i), 4'hF);
    wait_empty();
    check_log();

    // Store errors: sticky flag, first address kept, clear vs. new error
    err_addr = 32'h204; bus_lat = 1;
    store(32'h200, 32'h1, 4'hF);
    store(32'h204, 32'h2, 4'hF);
    store(32'h208, 32'h3, 4'hF);
    wait_empty();
    chk("serr_flag", {31'b0, store_err_o}, 32'd1);
    chk("serr_adr", store_err_adr_o, 32'h204);
    check_log();
    err_addr = 32'h208;
    store(32'h208, 32'h4, 4'hF);
    wait_empty();
    chk("serr_keep_flag", {31'b0, store_err_o}, 32'd1);
    chk("serr_keep_adr", store_err_adr_o, 32'h204);
    err_addr = 32'h20C; clear_with_err = 1;
    store(32'h20C, 32'h5, 4'hF);
    wait_empty();
    clear_with_err = 0;
    chk("serr_clr_coinc_flag", {31'b0, store_err_o}, 32'd1);
    chk("serr_clr_coinc_adr", store_err_adr_o, 32'h20C);
    @(negedge clk); clear_now = 1;
    @(negedge clk); clear_now = 0;
    @(posedge clk); #1;
    chk("serr_cleared", {31'b0, store_err_o}, 32'd0);
    err_addr = '1;
    check_log();

    // Random traffic against the ordering/memory model
    for (int i = 0; i < 150; i++) begin
      bit          we;
      logic [31:0] adr, dat;
      logic [3:0]  be;
      we  = ($urandom_range(0, 2) != 0);
      adr = 32'h300 + (32'($urandom_range(0, 15)) << 2);
      dat = $urandom;
      be  = 4'($urandom_range(1, 15));
      bus_lat = $urandom_range(0, 3);
      if (we) begin
        store(adr, dat, be);
        model_mem[adr[9:2]] = merge(model_mem[adr[9:2]], dat, be);
      end else begin
        do_op(1'b0, adr, 32'h0, be, a, e, d);
        exp_q.push_back('{1'b0, adr, 32'h0, be});
        chk("rand_rd_ack", {31'b0, a}, 32'd1);
        chk("rand_rdat", d, model_mem[adr[9:2]]);
      end
    end
    wait_empty();
    check_log();

    // Reset in the middle of a drain with 5 entries queued
    hold = 1; bus_lat = 0;
    for (int i = 0; i < 5; i++) store(32'h600 + 32'(i*4), 32'h6000 + 32'(i), 4'hF);
    @(posedge clk); #1;
    chk("rst_mid_req_before", {31'b0, bus_req_o}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_mid_empty", {31'b0, sb_empty_o}, 32'd1);
    chk("rst_mid_full", {31'b0, sb_full_o}, 32'd0);
    hold = 0;
    log_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_no_bus", 32'(req_cycles), 32'd0);
    chk("rst_mid_no_log", 32'(log_q.size()), 32'd0);
    chk("rst_mid_empty_after", {31'b0, sb_empty_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
